// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: core-wide register file widths and the XZR index
package wb_regfile_pkg;
  localparam int DATA_W = 64;
  localparam int REG_AW = 5;
  localparam logic [4:0] XZR_IDX = 5'd31;
  localparam int NUM_REGS = 32;
endpackage

// File: rtl/wb_regfile_regfile_array.sv
// regfile_array: 31-entry storage, one sync write port, two raw combinational read ports
module regfile_array #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int DEPTH = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && int'(waddr) < DEPTH) begin
      mem[waddr] <= wdata;
    end
  end
  // Indices beyond the storage read as zero so nothing can leak X
  assign rdata1 = (int'(raddr1) < DEPTH) ? mem[raddr1] : '0;
  assign rdata2 = (int'(raddr2) < DEPTH) ? mem[raddr2] : '0;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back mux plus register file with XZR masking and write-to-read bypass
module wb_regfile #(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int REG_AW = wb_regfile_pkg::REG_AW
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              regWrite_in,
  input  logic              memToReg_in,
  input  logic [DATA_W-1:0] memAddress_in,
  input  logic [DATA_W-1:0] memData_in,
  input  logic [REG_AW-1:0] writeReg_in,
  input  logic [REG_AW-1:0] readReg1,
  input  logic [REG_AW-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] writeData_out
);
  import wb_regfile_pkg::*;
  localparam logic [REG_AW-1:0] XZR = REG_AW'(XZR_IDX);
  logic              commit;
  logic [DATA_W-1:0] raw1, raw2;
  assign writeData_out = memToReg_in ? memData_in : memAddress_in;
  assign commit = regWrite_in && !RESET && writeReg_in != XZR;
  regfile_array #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(NUM_REGS - 1)) u_array (
    .clk(CLOCK),
    .rst(RESET),
    .we(commit),
    .waddr(writeReg_in),
    .wdata(writeData_out),
    .raddr1(readReg1),
    .raddr2(readReg2),
    .rdata1(raw1),
    .rdata2(raw2)
  );
  // commit already excludes XZR and reset, so it doubles as the bypass qualifier
  assign readData1 = (readReg1 == XZR) ? '0 : (commit && writeReg_in == readReg1) ? writeData_out : raw1;
  assign readData2 = (readReg2 == XZR) ? '0 : (commit && writeReg_in == readReg2) ? writeData_out : raw2;
endmodule
